// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl: command sequencer in front of a matmul engine.
// Accepts one command at a time (WRA/WRB buffer writes, START, RDC
// result reads through a single-row cache, STATUS) and returns one
// response word per command through a valid/ready handshake.
// Optional build macro: TPU_SEQ_TIMEOUT_EN adds a RUN-state watchdog
// that gives up after TIMEOUT_CYCLES and reports 32'hFFFF_FFFF.
module tpu_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IDX_W          = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_func,
  input  logic [31:0]      cmd_in0,
  input  logic [31:0]      cmd_in1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             a_we,
  output logic             b_we,
  output logic [IDX_W-1:0] a_index,
  output logic [IDX_W-1:0] b_index,
  output logic [31:0]      a_data,
  output logic [31:0]      b_data,
  output logic             tpu_start,
  output logic [7:0]       tpu_k,
  output logic [7:0]       tpu_m,
  output logic [7:0]       tpu_n,
  input  logic             tpu_done,
  output logic [IDX_W-1:0] c_index,
  input  logic [127:0]     c_data
);

  localparam logic [6:0] FN_WRA    = 7'd1;
  localparam logic [6:0] FN_WRB    = 7'd2;
  localparam logic [6:0] FN_START  = 7'd3;
  localparam logic [6:0] FN_RDC    = 7'd4;
  localparam logic [6:0] FN_STATUS = 7'd8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RUN     = 3'd2,
    RD_WAIT = 3'd3,
    RD_CAP  = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               a_we_q, a_we_d;
  logic               b_we_q, b_we_d;
  logic [IDX_W-1:0]   a_index_q, a_index_d;
  logic [IDX_W-1:0]   b_index_q, b_index_d;
  logic [31:0]        a_data_q, a_data_d;
  logic [31:0]        b_data_q, b_data_d;
  logic               tpu_start_q, tpu_start_d;
  logic [7:0]         tpu_k_q, tpu_k_d;
  logic [7:0]         tpu_m_q, tpu_m_d;
  logic [7:0]         tpu_n_q, tpu_n_d;
  logic [IDX_W-1:0]   c_index_q, c_index_d;
  logic               cache_vld_q, cache_vld_d;
  logic [IDX_W-1:0]   cache_row_q, cache_row_d;
  logic [127:0]       cache_data_q, cache_data_d;
  logic [1:0]         ws_q, ws_d;
  logic               run_active;
  logic               timeout_flag;
  logic [IDX_W-1:0]   rdc_row;

  // Word 0 is the most significant 32 bits of the result row.
  function automatic logic [31:0] sel_word(input logic [127:0] row,
                                           input logic [1:0]   ws);
    logic [31:0] w;
    case (ws)
      2'd0:    w = row[127:96];
      2'd1:    w = row[95:64];
      2'd2:    w = row[63:32];
      default: w = row[31:0];
    endcase
    return w;
  endfunction

`ifdef TPU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_flag_q, timeout_flag_d;

  assign timeout_flag = timeout_flag_q;

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q      <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q      <= tmo_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end
`else
  logic unused_timeout_param;

  assign timeout_flag         = 1'b0;
  assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
`endif

  logic unused_cmd_in1;
  assign unused_cmd_in1 = ^cmd_in1[31:IDX_W];

  assign rdc_row    = cmd_in0[IDX_W-1:0];
  assign run_active = (state_q == RUN);

  // Next-state and next-register logic for the command sequencer.
  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    a_we_d       = 1'b0;
    b_we_d       = 1'b0;
    a_index_d    = a_index_q;
    b_index_d    = b_index_q;
    a_data_d     = a_data_q;
    b_data_d     = b_data_q;
    tpu_start_d  = 1'b0;
    tpu_k_d      = tpu_k_q;
    tpu_m_d      = tpu_m_q;
    tpu_n_d      = tpu_n_q;
    c_index_d    = c_index_q;
    cache_vld_d  = cache_vld_q;
    cache_row_d  = cache_row_q;
    cache_data_d = cache_data_q;
    ws_d         = ws_q;
`ifdef TPU_SEQ_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    timeout_flag_d = timeout_flag_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ws_d = cmd_in1[1:0];
          case (cmd_func)
            FN_WRA: begin
              a_index_d = cmd_in1[IDX_W-1:0];
              a_data_d  = cmd_in0;
              a_we_d    = 1'b1;
              state_d   = WR;
            end
            FN_WRB: begin
              b_index_d = cmd_in1[IDX_W-1:0];
              b_data_d  = cmd_in0;
              b_we_d    = 1'b1;
              state_d   = WR;
            end
            FN_START: begin
              tpu_k_d     = cmd_in0[7:0];
              tpu_m_d     = cmd_in0[15:8];
              tpu_n_d     = cmd_in1[7:0];
              tpu_start_d = 1'b1;
              cache_vld_d = 1'b0;
`ifdef TPU_SEQ_TIMEOUT_EN
              tmo_cnt_d      = '0;
              timeout_flag_d = 1'b0;
`endif
              state_d     = RUN;
            end
            FN_RDC: begin
              if (cache_vld_q && (cache_row_q == rdc_row)) begin
                rsp_data_d = sel_word(cache_data_q, cmd_in1[1:0]);
                state_d    = RESP;
              end else begin
                // Result memory answers one cycle after the address moves.
                c_index_d = rdc_row;
                state_d   = RD_WAIT;
              end
            end
            FN_STATUS: begin
              rsp_data_d = {29'b0, timeout_flag, cache_vld_q, run_active};
              state_d    = RESP;
            end
            default: begin
              rsp_data_d = 32'h0;
              state_d    = RESP;
            end
          endcase
        end
      end
      WR: begin
        rsp_data_d = 32'h0;
        state_d    = RESP;
      end
      RUN: begin
        if (tpu_done) begin
          rsp_data_d = 32'd3;
          state_d    = RESP;
        end
`ifdef TPU_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_LAST) begin
          rsp_data_d     = 32'hFFFF_FFFF;
          timeout_flag_d = 1'b1;
          state_d        = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      RD_WAIT: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        cache_data_d = c_data;
        cache_row_d  = c_index_q;
        cache_vld_d  = 1'b1;
        rsp_data_d   = sel_word(c_data, ws_q);
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rsp_data_q  <= '0;
      a_we_q      <= 1'b0;
      b_we_q      <= 1'b0;
      a_index_q   <= '0;
      b_index_q   <= '0;
      a_data_q    <= '0;
      b_data_q    <= '0;
      tpu_start_q <= 1'b0;
      tpu_k_q     <= '0;
      tpu_m_q     <= '0;
      tpu_n_q     <= '0;
      c_index_q   <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_data_q  <= rsp_data_d;
      a_we_q      <= a_we_d;
      b_we_q      <= b_we_d;
      a_index_q   <= a_index_d;
      b_index_q   <= b_index_d;
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
      tpu_start_q <= tpu_start_d;
      tpu_k_q     <= tpu_k_d;
      tpu_m_q     <= tpu_m_d;
      tpu_n_q     <= tpu_n_d;
      c_index_q   <= c_index_d;
      cache_vld_q <= cache_vld_d;
    end
  end

  // Cache payload and word select; qualified by cache_vld_q / state, so no reset.
  always_ff @(posedge clk) begin
    cache_row_q  <= cache_row_d;
    cache_data_q <= cache_data_d;
    ws_q         <= ws_d;
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign a_we      = a_we_q;
  assign b_we      = b_we_q;
  assign a_index   = a_index_q;
  assign b_index   = b_index_q;
  assign a_data    = a_data_q;
  assign b_data    = b_data_q;
  assign tpu_start = tpu_start_q;
  assign tpu_k     = tpu_k_q;
  assign tpu_m     = tpu_m_q;
  assign tpu_n     = tpu_n_q;
  assign c_index   = c_index_q;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed testbench for tpu_seq_ctrl. Build with TPU_SEQ_TIMEOUT_EN
// defined to also exercise the RUN watchdog.
module tb_tpu_seq_ctrl;

  localparam int IDX_W = 12;
  localparam int TO    = 16;
`ifdef TPU_SEQ_TIMEOUT_EN
  localparam int DONE_DLY = 10;
`else
  localparam int DONE_DLY = 20;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [6:0]       cmd_func;
  logic [31:0]      cmd_in0;
  logic [31:0]      cmd_in1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             a_we, b_we;
  logic [IDX_W-1:0] a_index, b_index;
  logic [31:0]      a_data, b_data;
  logic             tpu_start;
  logic [7:0]       tpu_k, tpu_m, tpu_n;
  logic             tpu_done;
  logic [IDX_W-1:0] c_index;
  logic [127:0]     c_data;

  int checks = 0;
  int errors = 0;

  tpu_seq_ctrl #(.TIMEOUT_CYCLES(TO), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_in0(cmd_in0), .cmd_in1(cmd_in1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .a_we(a_we), .b_we(b_we), .a_index(a_index), .b_index(b_index),
    .a_data(a_data), .b_data(b_data),
    .tpu_start(tpu_start), .tpu_k(tpu_k), .tpu_m(tpu_m), .tpu_n(tpu_n),
    .tpu_done(tpu_done), .c_index(c_index), .c_data(c_data)
  );

  always #5 clk = ~clk;

  // Result memory model: row 7 holds words 1,2,3,4; other rows hold tagged words.
  function automatic logic [127:0] row_data(input logic [IDX_W-1:0] r);
    logic [31:0] t;
    t = {20'd0, r};
    if (r == 12'd7) return {32'd1, 32'd2, 32'd3, 32'd4};
    return {32'hA000_0000 | t, 32'hB000_0000 | t, 32'hC000_0000 | t, 32'hD000_0000 | t};
  endfunction

  always @(posedge clk) c_data <= row_data(c_index);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command and return one cycle after its acceptance edge.
  task automatic issue(input logic [6:0] f, input logic [31:0] i0, input logic [31:0] i1);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_func  = f;
    cmd_in0   = i0;
    cmd_in1   = i1;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({cmd_ready, rsp_valid, a_we, b_we, tpu_start} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: {rdy,rv,awe,bwe,start}=%b required 10000",
               {cmd_ready, rsp_valid, a_we, b_we, tpu_start});
    end
    checks++;
    if ({rsp_data, tpu_k, tpu_m, tpu_n, a_index, b_index, c_index, a_data, b_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: rsp_data=%h k=%h m=%h n=%h ai=%h bi=%h ci=%h ad=%h bd=%h required all 0",
               rsp_data, tpu_k, tpu_m, tpu_n, a_index, b_index, c_index, a_data, b_data);
    end
    reset = 1'b0;
    issue(7'd8, 32'd0, 32'd0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_status: rv=%b data=%h required 1/00000000", rsp_valid, rsp_data);
    end
    consume();
  endtask

  task automatic test_write();
    issue(7'd1, 32'hDEAD_BEEF, 32'h0000_0005);
    checks++;
    if (a_we !== 1'b1 || b_we !== 1'b0 || a_index !== 12'd5 || a_data !== 32'hDEAD_BEEF || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wra_strobe: awe=%b bwe=%b ai=%h ad=%h rv=%b required 1/0/005/deadbeef/0",
               a_we, b_we, a_index, a_data, rsp_valid);
    end
    step();
    checks++;
    if (a_we !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL wra_resp: awe=%b rv=%b data=%h required 0/1/00000000", a_we, rsp_valid, rsp_data);
    end
    consume();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wra_idle: rdy=%b rv=%b required 1/0", cmd_ready, rsp_valid);
    end
    issue(7'd2, 32'h1234_5678, 32'hFFFF_F0A3);
    checks++;
    if (b_we !== 1'b1 || a_we !== 1'b0 || b_index !== 12'h0A3 || b_data !== 32'h1234_5678 || a_index !== 12'd5) begin
      errors++;
      $display("FAIL wrb_strobe: bwe=%b awe=%b bi=%h bd=%h ai=%h required 1/0/0a3/12345678/005",
               b_we, a_we, b_index, b_data, a_index);
    end
    step();
    checks++;
    if (b_we !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL wrb_resp: bwe=%b rv=%b data=%h required 0/1/00000000", b_we, rsp_valid, rsp_data);
    end
    consume();
  endtask

  task automatic test_start();
    issue(7'd3, 32'h0000_0810, 32'h0000_0004);
    checks++;
    if (tpu_start !== 1'b1 || tpu_k !== 8'h10 || tpu_m !== 8'h08 || tpu_n !== 8'h04) begin
      errors++;
      $display("FAIL start_pulse: start=%b k=%h m=%h n=%h required 1/10/08/04", tpu_start, tpu_k, tpu_m, tpu_n);
    end
    step();
    checks++;
    if (tpu_start !== 1'b0) begin
      errors++;
      $display("FAIL start_once: start=%b required 0", tpu_start);
    end
    for (int i = 0; i < DONE_DLY - 2; i++) step();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_wait: rv=%b rdy=%b required 0/0", rsp_valid, cmd_ready);
    end
    tpu_done = 1'b1;
    step();
    tpu_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd3) begin
      errors++;
      $display("FAIL start_done: rv=%b data=%h required 1/00000003", rsp_valid, rsp_data);
    end
    consume();
  endtask

  task automatic test_rdc();
    issue(7'd4, 32'd7, 32'd1);
    checks++;
    if (rsp_valid !== 1'b0 || c_index !== 12'd7) begin
      errors++;
      $display("FAIL rdc_miss_c1: rv=%b cidx=%h required 0/007", rsp_valid, c_index);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdc_miss_c2: rv=%b required 0", rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd2) begin
      errors++;
      $display("FAIL rdc_miss_c3: rv=%b data=%h required 1/00000002", rsp_valid, rsp_data);
    end
    consume();
    issue(7'd4, 32'd7, 32'd3);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd4) begin
      errors++;
      $display("FAIL rdc_hit_ws3: rv=%b data=%h required 1/00000004", rsp_valid, rsp_data);
    end
    consume();
    issue(7'd4, 32'd7, 32'd0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd1) begin
      errors++;
      $display("FAIL rdc_hit_ws0: rv=%b data=%h required 1/00000001", rsp_valid, rsp_data);
    end
    consume();
    issue(7'd4, 32'd7, 32'd2);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd3) begin
      errors++;
      $display("FAIL rdc_hit_ws2: rv=%b data=%h required 1/00000003", rsp_valid, rsp_data);
    end
    consume();
    issue(7'd4, 32'd9, 32'd0);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdc_row9_miss: rv=%b required 0", rsp_valid);
    end
    step();
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hA000_0009) begin
      errors++;
      $display("FAIL rdc_row9_data: rv=%b data=%h required 1/a0000009", rsp_valid, rsp_data);
    end
    consume();
    issue(7'd1, 32'h5555_AAAA, 32'd9);
    step();
    consume();
    issue(7'd4, 32'd9, 32'd3);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hD000_0009) begin
      errors++;
      $display("FAIL rdc_hit_after_wra: rv=%b data=%h required 1/d0000009", rsp_valid, rsp_data);
    end
    consume();
  endtask

  task automatic test_hold();
    issue(7'd8, 32'd0, 32'd0);
    cmd_func  = 7'd1;
    cmd_in0   = 32'hCAFE_F00D;
    cmd_in1   = 32'd3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h2 || cmd_ready !== 1'b0 || a_we !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: rv=%b data=%h rdy=%b awe=%b required 1/00000002/0/0",
                 i, rsp_valid, rsp_data, cmd_ready, a_we);
      end
      step();
    end
    cmd_valid = 1'b0;
    consume();
    checks++;
    if (a_index !== 12'd9 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_no_accept: ai=%h rdy=%b required 009/1", a_index, cmd_ready);
    end
  endtask

  task automatic test_unknown();
    issue(7'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL unknown_func: rv=%b data=%h required 1/00000000", rsp_valid, rsp_data);
    end
    consume();
  endtask

  task automatic test_reset_resp();
    issue(7'd4, 32'd9, 32'd1);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hB000_0009) begin
      errors++;
      $display("FAIL rst_resp_hit: rv=%b data=%h required 1/b0000009", rsp_valid, rsp_data);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_resp_drop: rv=%b rdy=%b data=%h required 0/1/00000000", rsp_valid, cmd_ready, rsp_data);
    end
    issue(7'd4, 32'd9, 32'd1);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_cache_miss: rv=%b required 0", rsp_valid);
    end
    step();
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hB000_0009) begin
      errors++;
      $display("FAIL rst_cache_refill: rv=%b data=%h required 1/b0000009", rsp_valid, rsp_data);
    end
    consume();
  endtask

  task automatic test_reset_run();
    issue(7'd3, 32'h0000_0102, 32'd3);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || tpu_k !== 8'h0 || tpu_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_run: rdy=%b rv=%b k=%h start=%b required 1/0/00/0", cmd_ready, rsp_valid, tpu_k, tpu_start);
    end
    tpu_done = 1'b1;
    step();
    tpu_done = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_in_idle: rdy=%b rv=%b required 1/0", cmd_ready, rsp_valid);
    end
    issue(7'd4, 32'd7, 32'd3);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_miss: rv=%b required 0", rsp_valid);
    end
    step();
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd4) begin
      errors++;
      $display("FAIL rst_run_rdc: rv=%b data=%h required 1/00000004", rsp_valid, rsp_data);
    end
    consume();
  endtask

`ifdef TPU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    issue(7'd3, 32'h0000_0202, 32'd2);
    for (int i = 0; i < TO - 1; i++) step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: rv=%b required 0", rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL tmo_resp: rv=%b data=%h required 1/ffffffff", rsp_valid, rsp_data);
    end
    consume();
    issue(7'd8, 32'd0, 32'd0);
    checks++;
    if (rsp_data !== 32'h4) begin
      errors++;
      $display("FAIL tmo_status: data=%h required 00000004", rsp_data);
    end
    consume();
    issue(7'd3, 32'h0000_0202, 32'd2);
    tpu_done = 1'b1;
    step();
    tpu_done = 1'b0;
    consume();
    issue(7'd8, 32'd0, 32'd0);
    checks++;
    if (rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL tmo_flag_clear: data=%h required 00000000", rsp_data);
    end
    consume();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_func  = '0;
    cmd_in0   = '0;
    cmd_in1   = '0;
    rsp_ready = 1'b0;
    tpu_done  = 1'b0;
    #1;
    test_reset();
    test_write();
    test_start();
    test_rdc();
    test_hold();
    test_unknown();
    test_reset_resp();
    test_reset_run();
`ifdef TPU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_seq_ctrl.md
TPU_SEQ_CTRL -- requirements
Module: tpu_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: RUN-state cycle limit, used only when the timeout feature is compiled in.
REQ-002 Parameter IDX_W, default 12: buffer index width.
REQ-003 Clocking and reset: reset is synchronous and active-high; the clock is clk.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  controller accepts a command.
REQ-008 cmd_func  in  7  function id: 1=WRA, 2=WRB, 3=START, 4=RDC, 8=STATUS.
REQ-009 cmd_in0  in  32  operand 0.
REQ-010 cmd_in1  in  32  operand 1.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_data  out  32  response word.
REQ-014 a_we, b_we  out  1  one-cycle buffer write strobes.
REQ-015 a_index, b_index  out  IDX_W  buffer write addresses.
REQ-016 a_data, b_data  out  32  buffer write data.
REQ-017 tpu_start  out  1  one-cycle matmul launch pulse.
REQ-018 tpu_k, tpu_m, tpu_n  out  8  registered matrix dimensions.
REQ-019 tpu_done  in  1  matmul complete, level or pulse.
REQ-020 c_index  out  IDX_W  result row address.
REQ-021 c_data  in  128  result row; valid exactly one cycle after c_index changes.

Function
REQ-022 States: IDLE, WR, RUN, RD_WAIT, RD_CAP, RESP.
REQ-023 cmd_ready is 1 only in IDLE; a command is accepted on the cycle cmd_valid and cmd_ready are both 1.
REQ-024 WRA/WRB behaviour:
- On acceptance: index=cmd_in1[IDX_W-1:0], data=cmd_in0.
- Next cycle (WR): assert a_we or b_we for one cycle.
- Then RESP with rsp_data=0.
REQ-025 START behaviour:
- On acceptance: tpu_k=cmd_in0[7:0], tpu_m=cmd_in0[15:8], tpu_n=cmd_in1[7:0].
- Pulse tpu_start for one cycle, clear the result cache, enter RUN.
REQ-026 In RUN, tpu_done=1 moves the block to RESP with rsp_data=3; a tpu_done seen outside RUN is ignored.
REQ-027 RDC uses row=cmd_in0[IDX_W-1:0] and word select ws=cmd_in1[1:0]:
- Cache hit (cache valid and cached row equals row): go directly to RESP.
- Miss: drive c_index=row, go RD_WAIT, then RD_CAP, then capture c_data into the cache, set cache valid, go RESP.
REQ-028 RDC word order: ws=0 returns bits [127:96], 1 returns [95:64], 2 returns [63:32], 3 returns [31:0].
REQ-029 STATUS returns {29'b0, timeout_flag, cache_valid, run_active} and goes to RESP.
REQ-030 Any other cmd_func returns rsp_data=0 through RESP.
REQ-031 In RESP, rsp_valid=1 and rsp_data is held stable until rsp_ready=1; the block then returns to IDLE on the next cycle.
REQ-032 cmd_valid is ignored while rsp_valid=1; there is no command queuing.
REQ-033 Latency from acceptance to rsp_valid:
- WRA/WRB: 2 cycles.
- RDC hit: 1 cycle.
- RDC miss: 3 cycles.
- STATUS: 1 cycle.
- START: 1 cycle after tpu_done is sampled.
REQ-034 A WRA or WRB write does not invalidate the cache; only START or reset does.

Reset
REQ-035 On reset the state is IDLE and every output is at its reset value:
- cmd_ready=1.
- rsp_valid=0, rsp_data=0.
- All strobes 0.
- tpu_k, tpu_m, tpu_n, indices, a_data, b_data = 0.
- cache_valid=0, timeout_flag=0, timeout counter=0.
REQ-036 Reset asserted in any state, including RUN or RESP, takes effect on the next edge and drops any pending response.

Configuration
REQ-037 Macro TPU_SEQ_TIMEOUT_EN selects the RUN timeout.
- Defined: a counter clears on START and increments each RUN cycle. When it reaches TIMEOUT_CYCLES with no tpu_done, the block goes to RESP with rsp_data=32'hFFFF_FFFF and sets timeout_flag. The next START clears timeout_flag.
- Not defined: there is no counter; RUN waits indefinitely and timeout_flag is constant 0.

Verification
REQ-038 WRA with in0=0xDEADBEEF, in1=0x005 -> a_we=1 for one cycle with a_index=5 and a_data=0xDEADBEEF; rsp_data=0 two cycles after acceptance.
REQ-039 START with in0=0x0810, in1=0x04 -> tpu_k=0x10, tpu_m=0x08, tpu_n=0x04 and one tpu_start pulse; tpu_done raised 20 cycles later -> rsp_data=3.
REQ-040 RDC row 7 with ws=1 (miss), where c_data = 128'h0001..0004 (32-bit words 1,2,3,4 from bits [127:96] down) -> rsp_data=2 after 3 cycles; RDC row 7 with ws=3 -> rsp_data=4 after 1 cycle.
REQ-041 Response held with rsp_ready=0 for 5 cycles while cmd_valid=1 -> rsp_data stable, cmd_ready=0, no new command accepted.
REQ-042 TPU_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, START with no tpu_done -> rsp_data=0xFFFFFFFF 16 cycles into RUN; a following STATUS returns 0x4.
REQ-043 Reset asserted mid-RUN -> next cycle IDLE, cmd_ready=1, rsp_valid=0; a subsequent RDC is a cache miss.
